// File: rtl/fsm_dispatcher.sv
// Job dispatcher for the 4-state fsm worker: queues job IDs, issues one go pulse
// per job, and reports each job's completion (done or timeout) with its ID.
module fsm_dispatcher #(
  parameter int ID_W    = 4,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  input  logic [ID_W-1:0]            req_id,
  output logic                       req_ready,
  output logic                       go,
  input  logic                       worker_done,
  output logic                       cpl_valid,
  output logic [ID_W-1:0]            cpl_id,
  output logic                       cpl_err,
  output logic [$clog2(DEPTH):0]     pending,
  output logic                       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_GO, S_WAIT} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [PW-1:0]     count;
  logic [TW-1:0]     timer, timer_nxt;
  logic [ID_W-1:0]   cur_id, cur_id_nxt;
  logic              go_nxt, cpl_valid_nxt, cpl_err_nxt;
  logic [ID_W-1:0]   cpl_id_nxt;
  logic              full, push, pop;

  assign full      = (count == PW'(DEPTH));
  assign req_ready = !full && !rst;
  assign push      = req_valid && req_ready;
  // Pop decision uses pre-edge occupancy, so a job pushed this edge is never bypassed.
  assign pop       = (state == S_IDLE) && (count != '0);
  assign pending   = count;
  assign busy      = (state != S_IDLE);

  always_comb begin
    state_nxt     = state;
    timer_nxt     = timer;
    cur_id_nxt    = cur_id;
    go_nxt        = 1'b0;
    cpl_valid_nxt = 1'b0;
    cpl_id_nxt    = cpl_id;
    cpl_err_nxt   = cpl_err;
    case (state)
      S_IDLE: begin
        if (pop) begin
          cur_id_nxt = mem[rd_ptr];
          go_nxt     = 1'b1;
          state_nxt  = S_GO;
        end
      end
      S_GO: begin
        timer_nxt = '0;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // Done takes priority over an expiring timer.
        if (worker_done) begin
          cpl_valid_nxt = 1'b1;
          cpl_id_nxt    = cur_id;
          cpl_err_nxt   = 1'b0;
          state_nxt     = S_IDLE;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          cpl_valid_nxt = 1'b1;
          cpl_id_nxt    = cur_id;
          cpl_err_nxt   = 1'b1;
          state_nxt     = S_IDLE;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      timer     <= '0;
      cur_id    <= '0;
      go        <= 1'b0;
      cpl_valid <= 1'b0;
      cpl_id    <= '0;
      cpl_err   <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      cur_id    <= cur_id_nxt;
      go        <= go_nxt;
      cpl_valid <= cpl_valid_nxt;
      cpl_id    <= cpl_id_nxt;
      cpl_err   <= cpl_err_nxt;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + PW'(1);
        2'b01:   count <= count - PW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= req_id;
  end

endmodule

// File: tb/tb_fsm_dispatcher.sv
// Directed self-checking bench for fsm_dispatcher with a behavioural 4-cycle worker.
module tb_fsm_dispatcher;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [3:0] req_id = '0;
  logic       req_ready;
  logic       go;
  logic       worker_done;
  logic       cpl_valid;
  logic [3:0] cpl_id;
  logic       cpl_err;
  logic [2:0] pending;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // Worker: samples go, raises done for one cycle 3 edges later.
  logic [1:0] wk_cnt;
  logic       wk_done;
  logic       wk_en = 1'b1;
  logic       force_done = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      wk_cnt  <= '0;
      wk_done <= 1'b0;
    end else if (go) begin
      wk_cnt  <= 2'd3;
      wk_done <= 1'b0;
    end else if (wk_cnt != 0) begin
      wk_cnt  <= wk_cnt - 2'd1;
      wk_done <= (wk_cnt == 2'd1);
    end else begin
      wk_done <= 1'b0;
    end
  end

  assign worker_done = wk_en ? wk_done : force_done;

  always #5 clk = ~clk;

  fsm_dispatcher #(.ID_W(4), .DEPTH(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_id(req_id),
    .req_ready(req_ready), .go(go), .worker_done(worker_done),
    .cpl_valid(cpl_valid), .cpl_id(cpl_id), .cpl_err(cpl_err),
    .pending(pending), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = 1'b0; force_done = 1'b0; wk_en = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b1; req_id = 4'hF;
    tick(); tick();
    checks++;
    if ({go, cpl_valid, cpl_err, busy} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {go, cpl_valid, cpl_err, busy});
    end
    checks++;
    if (cpl_id !== 4'h0) begin errors++; $display("FAIL reset_cpl_id: got %0h expected 0", cpl_id); end
    checks++;
    if (pending !== 3'd0) begin errors++; $display("FAIL reset_pending: got %0d expected 0", pending); end
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", req_ready); end
    rst = 1'b0; req_valid = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b expected 1", req_ready); end
    tick();
    checks++;
    if (pending !== 3'd0) begin errors++; $display("FAIL post_reset_pending: got %0d expected 0", pending); end
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 1'b1; req_id = 4'd5;
    tick();
    req_valid = 1'b0;
    checks++;
    if (pending !== 3'd1 || go !== 1'b0) begin
      errors++; $display("FAIL single_e0: got pending=%0d go=%b expected pending=1 go=0", pending, go);
    end
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks++;
      if (go !== (e == 1)) begin errors++; $display("FAIL single_go e%0d: got %b expected %b", e, go, (e == 1)); end
      checks++;
      if (cpl_valid !== (e == 6)) begin
        errors++; $display("FAIL single_cpl_valid e%0d: got %b expected %b", e, cpl_valid, (e == 6));
      end
      checks++;
      if (busy !== (e >= 1 && e <= 5)) begin
        errors++; $display("FAIL single_busy e%0d: got %b expected %b", e, busy, (e >= 1 && e <= 5));
      end
      if (e == 6) begin
        checks++;
        if (cpl_id !== 4'd5 || cpl_err !== 1'b0) begin
          errors++; $display("FAIL single_cpl e6: got id=%0d err=%b expected id=5 err=0", cpl_id, cpl_err);
        end
      end
      if (e == 1) begin
        checks++;
        if (pending !== 3'd0) begin errors++; $display("FAIL single_pending e1: got %0d expected 0", pending); end
      end
    end
  endtask

  task automatic test_fill_drain();
    int exp_id [6]   = '{6, 1, 2, 3, 4, 5};
    int exp_edge [6] = '{6, 12, 18, 24, 30, 36};
    int exp_pend [4] = '{4, 4, 3, 4};
    int exp_rdy [4]  = '{0, 0, 1, 0};
    int ncpl = 0;
    logic go_prev = 1'b0;
    do_reset();
    req_valid = 1'b1; req_id = 4'd6;
    for (int e = 0; e <= 40; e++) begin
      int n;
      tick();
      checks++;
      if (go && go_prev) begin errors++; $display("FAIL fill_go_consecutive e%0d: got 1 expected 0", e); end
      go_prev = go;
      if (e >= 5 && e <= 8) begin
        checks++;
        if (pending !== 3'(exp_pend[e-5]) || req_ready !== 1'(exp_rdy[e-5])) begin
          errors++;
          $display("FAIL fill_occupancy e%0d: got pending=%0d ready=%b expected pending=%0d ready=%0d",
                   e, pending, req_ready, exp_pend[e-5], exp_rdy[e-5]);
        end
      end
      if (cpl_valid) begin
        checks++;
        if (ncpl >= 6) begin
          errors++; $display("FAIL fill_extra_cpl e%0d: got id=%0d expected none", e, cpl_id);
        end else if (int'(cpl_id) != exp_id[ncpl] || e != exp_edge[ncpl] || cpl_err !== 1'b0) begin
          errors++;
          $display("FAIL fill_cpl%0d: got id=%0d edge=%0d err=%b expected id=%0d edge=%0d err=0",
                   ncpl, cpl_id, e, cpl_err, exp_id[ncpl], exp_edge[ncpl]);
        end
        ncpl++;
      end
      n = e + 1;
      if (n >= 2 && n <= 5) begin req_valid = 1'b1; req_id = 4'(n - 1); end
      else if (n >= 6 && n <= 8) begin req_valid = 1'b1; req_id = 4'd5; end
      else req_valid = 1'b0;
    end
    checks++;
    if (ncpl != 6) begin errors++; $display("FAIL fill_cpl_count: got %0d expected 6", ncpl); end
    checks++;
    if (pending !== 3'd0) begin errors++; $display("FAIL fill_final_pending: got %0d expected 0", pending); end
  endtask

  task automatic test_timeout();
    int exp_id [2]   = '{9, 3};
    int exp_err [2]  = '{1, 0};
    int exp_edge [2] = '{18, 25};
    int exp_go [2]   = '{1, 20};
    int ncpl = 0;
    int ngo = 0;
    do_reset();
    wk_en = 1'b0;
    req_valid = 1'b1; req_id = 4'd9;
    for (int e = 0; e <= 30; e++) begin
      tick();
      if (go) begin
        checks++;
        if (ngo >= 2 || e != exp_go[ngo < 2 ? ngo : 0]) begin
          errors++; $display("FAIL timeout_go%0d: got edge %0d expected edge %0d", ngo, e, exp_go[ngo < 2 ? ngo : 0]);
        end
        ngo++;
      end
      if (cpl_valid) begin
        checks++;
        if (ncpl >= 2) begin
          errors++; $display("FAIL timeout_extra_cpl e%0d: got id=%0d expected none", e, cpl_id);
        end else if (int'(cpl_id) != exp_id[ncpl] || int'(cpl_err) != exp_err[ncpl] || e != exp_edge[ncpl]) begin
          errors++;
          $display("FAIL timeout_cpl%0d: got id=%0d err=%b edge=%0d expected id=%0d err=%0d edge=%0d",
                   ncpl, cpl_id, cpl_err, e, exp_id[ncpl], exp_err[ncpl], exp_edge[ncpl]);
        end
        ncpl++;
      end
      if (e == 18) wk_en = 1'b1;
      if (e + 1 == 19) begin req_valid = 1'b1; req_id = 4'd3; end
      else req_valid = 1'b0;
    end
    checks++;
    if (ncpl != 2 || ngo != 2) begin
      errors++; $display("FAIL timeout_counts: got cpl=%0d go=%0d expected cpl=2 go=2", ncpl, ngo);
    end
  endtask

  task automatic test_done_last();
    int ncpl = 0;
    do_reset();
    wk_en = 1'b0;
    req_valid = 1'b1; req_id = 4'd7;
    for (int e = 0; e <= 25; e++) begin
      tick();
      req_valid = 1'b0;
      force_done = (e == 17);
      if (cpl_valid) begin
        checks++;
        if (e != 18 || cpl_id !== 4'd7 || cpl_err !== 1'b0) begin
          errors++; $display("FAIL done_last_cpl: got edge=%0d id=%0d err=%b expected edge=18 id=7 err=0",
                             e, cpl_id, cpl_err);
        end
        ncpl++;
      end
    end
    checks++;
    if (ncpl != 1) begin errors++; $display("FAIL done_last_count: got %0d expected 1", ncpl); end
  endtask

  task automatic test_reset_mid();
    int ncpl = 0;
    int ngo = 0;
    do_reset();
    req_valid = 1'b1; req_id = 4'd2;
    for (int e = 0; e <= 3; e++) begin
      tick();
      if (e + 1 == 2) begin req_valid = 1'b1; req_id = 4'd4; end
      else if (e + 1 == 3) begin req_valid = 1'b1; req_id = 4'd8; end
      else req_valid = 1'b0;
    end
    checks++;
    if (pending !== 3'd2 || busy !== 1'b1) begin
      errors++; $display("FAIL mid_pre: got pending=%0d busy=%b expected pending=2 busy=1", pending, busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (pending !== 3'd0 || busy !== 1'b0 || go !== 1'b0 || req_ready !== 1'b1 || cpl_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_after_reset: got pending=%0d busy=%b go=%b ready=%b cpl=%b expected 0 0 0 1 0",
               pending, busy, go, req_ready, cpl_valid);
    end
    for (int e = 0; e < 15; e++) begin
      tick();
      if (cpl_valid) ncpl++;
      if (go) ngo++;
    end
    checks++;
    if (ncpl != 0 || ngo != 0) begin
      errors++; $display("FAIL mid_no_activity: got cpl=%0d go=%0d expected 0 0", ncpl, ngo);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_timeout();
    test_done_last();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
